// File: rtl/dmac_ch_arb.sv
// Round-robin arbiter granting one of CH_NUM DMA channels access to the shared AHB master port.
// Optional grant-hold timeout enabled by defining DMAC_ARB_TOUT_EN.
module dmac_ch_arb #(
  parameter int unsigned CH_NUM   = 4,
  parameter int unsigned TOUT_CYC = 64
) (
  input  logic                      hclk,
  input  logic                      hrst_n,
  input  logic [CH_NUM-1:0]         ch_req,
  input  logic [CH_NUM-1:0]         ch_done,
  output logic [CH_NUM-1:0]         ch_gnt,
  output logic [$clog2(CH_NUM)-1:0] gnt_id,
  output logic                      m_hbusreq,
  input  logic                      m_hgrant,
  input  logic                      m_hready,
  output logic                      arb_busy,
  output logic                      arb_tout
);

  localparam int unsigned ID_W = $clog2(CH_NUM);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSREQ  = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_nxt_state;
  logic [CH_NUM-1:0] r_gnt;
  logic [CH_NUM-1:0] w_nxt_gnt;
  logic [ID_W-1:0]   r_gnt_id;
  logic [ID_W-1:0]   w_nxt_gnt_id;
  logic [ID_W-1:0]   r_last_id;
  logic [ID_W-1:0]   w_nxt_last_id;
  logic              r_busreq;
  logic              w_nxt_busreq;
  logic              r_busy;
  logic              w_nxt_busy;
  logic [ID_W-1:0]   w_rr_idx;
  logic [ID_W-1:0]   w_rr_pick;

`ifdef DMAC_ARB_TOUT_EN
  localparam int unsigned CNT_W = $clog2(TOUT_CYC);

  logic [CNT_W-1:0]  r_tout_cnt;
  logic              r_arb_tout;
  logic              w_tout_due;
  logic              w_tout_hit;
`endif

  if ((CH_NUM < 2) || (CH_NUM > 8) || (TOUT_CYC < 2)) begin : g_param_err
    $error("dmac_ch_arb: CH_NUM must be 2..8 and TOUT_CYC at least 2");
  end

  // Round-robin search from last_id+1; scanning backwards lets the nearest requester win.
  always_comb begin : rr_search
    w_rr_idx  = '0;
    w_rr_pick = '0;
    for (int unsigned off = CH_NUM; off >= 1; off--) begin
      w_rr_idx = ID_W'((32'(r_last_id) + off) % CH_NUM);
      if (ch_req[w_rr_idx]) begin
        w_rr_pick = w_rr_idx;
      end
    end
  end

  // Next-state and next-output decode; all outputs are registered from the next state.
  always_comb begin : fsm_next
    w_nxt_state   = r_state;
    w_nxt_gnt_id  = r_gnt_id;
    w_nxt_last_id = r_last_id;
`ifdef DMAC_ARB_TOUT_EN
    w_tout_hit    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (|ch_req) begin
          w_nxt_state  = ST_BUSREQ;
          w_nxt_gnt_id = w_rr_pick;
        end
      end
      ST_BUSREQ: begin
        if (m_hgrant && m_hready) begin
          w_nxt_state = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // End of burst outranks timeout, which outranks bus-grant loss.
        if (ch_done[r_gnt_id] || !ch_req[r_gnt_id]) begin
          w_nxt_state = ST_RELEASE;
`ifdef DMAC_ARB_TOUT_EN
        end else if (w_tout_due) begin
          w_nxt_state = ST_RELEASE;
          w_tout_hit  = 1'b1;
`endif
        end else if (!m_hgrant) begin
          w_nxt_state = ST_BUSREQ;
        end
      end
      ST_RELEASE: begin
        w_nxt_state   = ST_IDLE;
        w_nxt_last_id = r_gnt_id;
        w_nxt_gnt_id  = '0;
      end
      default: begin
        w_nxt_state  = ST_IDLE;
        w_nxt_gnt_id = '0;
      end
    endcase

    w_nxt_busreq = (w_nxt_state == ST_BUSREQ) || (w_nxt_state == ST_GRANT);
    w_nxt_busy   = (w_nxt_state != ST_IDLE);
    w_nxt_gnt    = (w_nxt_state == ST_GRANT) ? (CH_NUM'(1) << w_nxt_gnt_id) : '0;
  end

  always_ff @(posedge hclk or negedge hrst_n) begin : state_reg
    if (!hrst_n) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_last_id <= ID_W'(CH_NUM - 1);
      r_busreq  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_gnt     <= w_nxt_gnt;
      r_gnt_id  <= w_nxt_gnt_id;
      r_last_id <= w_nxt_last_id;
      r_busreq  <= w_nxt_busreq;
      r_busy    <= w_nxt_busy;
    end
  end

`ifdef DMAC_ARB_TOUT_EN
  assign w_tout_due = (r_tout_cnt == CNT_W'(TOUT_CYC - 1));

  // Grant-hold counter: cleared on every entry to GRANT, counts GRANT cycles.
  always_ff @(posedge hclk or negedge hrst_n) begin : tout_reg
    if (!hrst_n) begin
      r_tout_cnt <= '0;
      r_arb_tout <= 1'b0;
    end else begin
      r_arb_tout <= w_tout_hit;
      if ((r_state != ST_GRANT) && (w_nxt_state == ST_GRANT)) begin
        r_tout_cnt <= '0;
      end else if (r_state == ST_GRANT) begin
        r_tout_cnt <= r_tout_cnt + CNT_W'(1);
      end
    end
  end

  assign arb_tout = r_arb_tout;
`else
  assign arb_tout = 1'b0;
`endif

  assign ch_gnt    = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign m_hbusreq = r_busreq;
  assign arb_busy  = r_busy;

endmodule

// File: doc/dmac_ch_arb.md
DMAC_CH_ARB -- requirements
Module: dmac_ch_arb

Interface
REQ-001 Parameter CH_NUM, default 4, number of DMA channels sharing the AHB master port (2..8).
REQ-002 Parameter TOUT_CYC, default 64, grant-hold limit in hclk cycles, used only with DMAC_ARB_TOUT_EN.
REQ-003 Port hclk  input  1  single clock; all logic on rising edge.
REQ-004 Port hrst_n  input  1  asynchronous active-low reset.
REQ-005 Port ch_req  input  CH_NUM  per-channel bus request, level; held until done.
REQ-006 Port ch_done  input  CH_NUM  per-channel one-cycle pulse, end of burst.
REQ-007 Port ch_gnt  output  CH_NUM  one-hot channel grant, registered.
REQ-008 Port gnt_id  output  clog2(CH_NUM)  index of the selected channel, registered.
REQ-009 Port m_hbusreq  output  1  AHB master bus request.
REQ-010 Port m_hgrant  input  1  AHB bus grant.
REQ-011 Port m_hready  input  1  AHB transfer ready.
REQ-012 Port arb_busy  output  1  high in any state other than IDLE.
REQ-013 Port arb_tout  output  1  one-cycle timeout pulse; tied 0 without DMAC_ARB_TOUT_EN.

Function
REQ-014 The FSM SHALL have the states IDLE, BUSREQ, GRANT and RELEASE.
REQ-015 IDLE: when any ch_req is high, select the first requester round-robin, starting at last_id+1 and wrapping CH_NUM-1 to 0; latch it in gnt_id; go to BUSREQ.
REQ-016 IDLE with no request: stay in IDLE with all outputs 0.
REQ-017 BUSREQ: drive m_hbusreq=1; when m_hgrant=1 and m_hready=1 in the same cycle, go to GRANT; ch_gnt[gnt_id]=1 from the next cycle.
REQ-018 GRANT: hold ch_gnt and m_hbusreq; ch_done[gnt_id]=1 or ch_req[gnt_id]=0 goes to RELEASE.
REQ-019 GRANT: ignore ch_done from non-granted channels.
REQ-020 GRANT: if m_hgrant falls, clear ch_gnt next cycle and return to BUSREQ with gnt_id unchanged; the channel resumes once the grant is regained.
REQ-021 RELEASE: lasts one cycle; m_hbusreq=0 and ch_gnt=0; last_id<=gnt_id; go to IDLE.
REQ-022 Minimum re-arbitration gap after a done SHALL be 2 cycles (RELEASE, then IDLE).
REQ-023 New requests arriving during BUSREQ, GRANT or RELEASE SHALL NOT change gnt_id.
REQ-024 ch_gnt SHALL never have more than one bit set.

Reset
REQ-025 Asynchronous assertion of hrst_n=0 SHALL force IDLE, ch_gnt=0, gnt_id=0, m_hbusreq=0, arb_busy=0, arb_tout=0, timeout counter=0 and last_id=CH_NUM-1, so channel 0 wins first.
REQ-026 Reset mid-grant SHALL drop ch_gnt and m_hbusreq immediately, without waiting for a clock edge.

Configuration
REQ-027 With macro DMAC_ARB_TOUT_EN defined, a counter SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-028 With DMAC_ARB_TOUT_EN defined, the GRANT cycle in which the counter reaches TOUT_CYC-1 without a done SHALL pulse arb_tout for one cycle and go to RELEASE.
REQ-029 With DMAC_ARB_TOUT_EN defined, a done in that same cycle SHALL take priority, with no arb_tout pulse.
REQ-030 Without DMAC_ARB_TOUT_EN, no counter SHALL exist, arb_tout SHALL be constant 0, and GRANT SHALL be held indefinitely.

Verification
REQ-031 Scenario: ch_req=4'b0001, m_hgrant=1, m_hready=1 -> m_hbusreq high 1 cycle after the request, ch_gnt=0001 2 cycles later; ch_done[0] pulse -> ch_gnt=0 and m_hbusreq=0 the next cycle.
REQ-032 Scenario: ch_req=4'b1111 held, each grant ended by its done -> grant order 0,1,2,3,0.
REQ-033 Scenario: ch_req=4'b0101 with last_id=2 -> channel 0 granted, then channel 2.
REQ-034 Scenario: m_hgrant dropped for 3 cycles during a channel 1 grant -> ch_gnt=0 during the loss, channel 1 regranted with gnt_id=1 after m_hgrant returns.
REQ-035 Scenario: DMAC_ARB_TOUT_EN defined, TOUT_CYC=64, no done -> arb_tout pulse on GRANT cycle 64, grant released, next requester served.
REQ-036 Scenario: hrst_n pulsed low during GRANT -> all outputs 0 asynchronously; after release, channel 0 wins first.
